// File: rtl/gate_chk_pkg.sv
// Shared types and golden truth table for the gate-bank vector checker.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StSample,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned G_AND   = 0;
  localparam int unsigned G_OR    = 1;
  localparam int unsigned G_NOT   = 2;
  localparam int unsigned G_NAND  = 3;
  localparam int unsigned G_NOR   = 4;
  localparam int unsigned G_XNOR  = 5;
  localparam int unsigned G_XOR   = 6;
  localparam int unsigned NumGates = 7;

  function automatic logic [NumGates-1:0] gate_golden(input logic a, input logic b);
    logic [NumGates-1:0] g;
    g         = '0;
    g[G_AND]  = a & b;
    g[G_OR]   = a | b;
    g[G_NOT]  = ~a;
    g[G_NAND] = ~(a & b);
    g[G_NOR]  = ~(a | b);
    g[G_XNOR] = ~(a ^ b);
    g[G_XOR]  = a ^ b;
    return g;
  endfunction

endpackage

// File: rtl/gate_vector_checker_settle_timer.sv
// Loadable down-counter with zero flag; paces how long each vector is held.
module settle_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps a/b through all four combinations, samples the gate bank after a settle
// interval and compares against the golden truth table.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask,
  output logic [2:0] fail_cnt,
  output logic [1:0] first_fail
);

  localparam int unsigned CntW = $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [6:0] err_mask_q, err_mask_d;
  logic [2:0] fail_cnt_q, fail_cnt_d;
  logic [1:0] first_fail_q, first_fail_d;
  logic [6:0] y_q, y_d;

  logic       timer_load, timer_dec, timer_zero;
  logic [6:0] mism;
  logic [1:0] idx_next;

  settle_timer #(
    .Width(CntW)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .load_val_i(LoadVal),
    .dec_i     (timer_dec),
    .zero_o    (timer_zero)
  );

  assign idx_next = idx_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_mask_d   = err_mask_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    y_d          = y_q;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;
    mism         = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StDrive;
          busy_d       = 1'b1;
          idx_d        = 2'd0;
          a_d          = 1'b0;
          b_d          = 1'b0;
          pass_d       = 1'b0;
          err_mask_d   = '0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
        end
      end
      StDrive: begin
        timer_load = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (timer_zero) begin
          state_d = StSample;
        end else begin
          timer_dec = 1'b1;
        end
      end
      StSample: begin
        y_d     = y;
        state_d = StCheck;
      end
      StCheck: begin
        mism       = y_q ^ gate_golden(idx_q[1], idx_q[0]);
        err_mask_d = err_mask_q | mism;
        if (mism != '0) begin
          fail_cnt_d = fail_cnt_q + 3'd1;
          if (fail_cnt_q == '0) begin
            first_fail_d = idx_q;
          end
        end
        if (idx_q == 2'd3) begin
          // Verdict is registered alongside done so both are valid in the same cycle.
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_mask_d == '0);
        end else begin
          idx_d      = idx_next;
          {a_d, b_d} = idx_next;
          state_d    = StDrive;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_mask_q   <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_mask_q   <= err_mask_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      y_q          <= y_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_mask   = err_mask_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized bench for gate_vector_checker: three instances (SETTLE 2, 1, 255), each
// driving its own behavioural gate bank with selectable faults.
module tb_gate_vector_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] a_v, b_v, busy_v, done_v, pass_v;
  logic [6:0] y_v   [3];
  logic [6:0] err_v [3];
  logic [2:0] fc_v  [3];
  logic [1:0] ff_v  [3];

  // Bank mode: 0 correct, 1 XNOR/XOR swapped, 2 AND stuck-at-1, 3 random per-vector flips.
  int         mode_v [3];
  logic [6:0] fx     [3][4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_golden(input logic a, input logic b);
    logic [6:0] r;
    r    = '0;
    r[0] = a & b;
    r[1] = a | b;
    r[2] = !a;
    r[3] = !(a & b);
    r[4] = !(a | b);
    r[5] = (a == b);
    r[6] = (a != b);
    return r;
  endfunction

  function automatic logic [6:0] bank_out(input int mode, input logic [6:0] x,
                                          input logic a, input logic b);
    logic [6:0] g, r;
    g = ref_golden(a, b);
    r = g;
    case (mode)
      1: begin
        r[5] = g[6];
        r[6] = g[5];
      end
      2: r = g | 7'h01;
      3: r = g ^ x;
      default: r = g;
    endcase
    return r;
  endfunction

  function automatic int settle_of(input int d);
    if (d == 0) return 2;
    if (d == 1) return 1;
    return 255;
  endfunction

  assign y_v[0] = bank_out(mode_v[0], fx[0][{a_v[0], b_v[0]}], a_v[0], b_v[0]);
  assign y_v[1] = bank_out(mode_v[1], fx[1][{a_v[1], b_v[1]}], a_v[1], b_v[1]);
  assign y_v[2] = bank_out(mode_v[2], fx[2][{a_v[2], b_v[2]}], a_v[2], b_v[2]);

  gate_vector_checker #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .y(y_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_mask(err_v[0]),
    .fail_cnt(fc_v[0]), .first_fail(ff_v[0])
  );

  gate_vector_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .y(y_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_mask(err_v[1]),
    .fail_cnt(fc_v[1]), .first_fail(ff_v[1])
  );

  gate_vector_checker #(.SETTLE(255)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .y(y_v[2]), .a(a_v[2]), .b(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_mask(err_v[2]),
    .fail_cnt(fc_v[2]), .first_fail(ff_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check_eq(tag, {a_v[d], b_v[d], busy_v[d], done_v[d], pass_v[d], err_v[d], fc_v[d],
                   ff_v[d]}, 32'd0);
  endtask

  task automatic randomize_faults(input int d);
    for (int v = 0; v < 4; v++) begin
      fx[d][v] = ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom);
    end
  endtask

  // One full sweep on instance d with a single-cycle start pulse, checked against the model.
  task automatic run_sweep(input int d);
    logic [6:0] exp_err, mism;
    int         exp_fc, exp_ff, k, s, lat, limit;
    logic [1:0] seq[$];
    logic [1:0] ab;
    logic       got_done, seq_ok;

    exp_err = '0;
    exp_fc  = 0;
    exp_ff  = 0;
    for (int v = 0; v < 4; v++) begin
      mism = bank_out(mode_v[d], fx[d][v], v[1], v[0]) ^ ref_golden(v[1], v[0]);
      if (mism != 0) begin
        if (exp_fc == 0) exp_ff = v;
        exp_fc++;
      end
      exp_err |= mism;
    end

    s     = settle_of(d);
    lat   = 4 * (s + 3) + 1;
    limit = lat + 50;
    seq.delete();
    got_done = 1'b0;
    k        = 0;

    @(negedge clk);
    start_v[d] = 1'b1;
    while (!got_done && k < limit) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start_v[d] = 1'b0;
        check_eq("busy_after_start", busy_v[d], 1'b1);
      end
      ab = {a_v[d], b_v[d]};
      if (seq.size() == 0 || seq[$] != ab) seq.push_back(ab);
      if (done_v[d]) got_done = 1'b1;
    end

    check_eq("done_seen", got_done, 1'b1);
    check_eq("latency", k, lat);
    seq_ok = (seq.size() == 4);
    for (int i = 0; i < seq.size() && i < 4; i++) begin
      if (seq[i] != 2'(i)) seq_ok = 1'b0;
    end
    check_eq("ab_sequence", seq_ok, 1'b1);
    check_eq("pass", pass_v[d], (exp_err == 0));
    check_eq("err_mask", err_v[d], exp_err);
    check_eq("fail_cnt", fc_v[d], exp_fc);
    check_eq("first_fail", ff_v[d], exp_ff);

    @(negedge clk);
    check_eq("done_one_cycle", done_v[d], 1'b0);
    check_eq("busy_after_done", busy_v[d], 1'b0);
    check_eq("pass_held", pass_v[d], (exp_err == 0));
    check_eq("err_held", err_v[d], exp_err);
  endtask

  initial begin
    int k, ndone;
    logic got_done;

    rst     = 1'b1;
    start_v = '0;
    for (int d = 0; d < 3; d++) begin
      mode_v[d] = 0;
      for (int v = 0; v < 4; v++) fx[d][v] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset_vals(d, "reset_vals");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good bank.
    run_sweep(0);
    check_eq("good_pass", pass_v[0], 1'b1);

    // XNOR/XOR swapped: both wrong on every vector.
    mode_v[0] = 1;
    run_sweep(0);
    check_eq("swap_err", err_v[0], 7'b110_0000);
    check_eq("swap_fc", fc_v[0], 3'd4);
    check_eq("swap_ff", ff_v[0], 2'd0);

    // AND stuck-at-1: wrong on 00, 01, 10.
    mode_v[0] = 2;
    run_sweep(0);
    check_eq("stuck_err", err_v[0], 7'b000_0001);
    check_eq("stuck_fc", fc_v[0], 3'd3);
    check_eq("stuck_ff", ff_v[0], 2'd0);
    check_eq("stuck_pass", pass_v[0], 1'b0);

    // Reset mid-sweep.
    mode_v[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    got_done   = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) start_v[0] = 1'b0;
      if (done_v[0]) got_done = 1'b1;
    end
    rst = 1'b1;
    #1;
    check_reset_vals(0, "midsweep_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_v[0]) got_done = 1'b1;
    end
    check_eq("no_done_after_abort", got_done, 1'b0);
    check_eq("idle_after_abort", busy_v[0], 1'b0);
    run_sweep(0);
    check_eq("post_reset_pass", pass_v[0], 1'b1);

    // start held high for 30 cycles.
    @(negedge clk);
    start_v[0] = 1'b1;
    ndone      = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
      if (k == 21) check_eq("hold_done_at_21", done_v[0], 1'b1);
      if (k == 22) check_eq("hold_busy_falls", busy_v[0], 1'b0);
      if (k == 23) check_eq("hold_busy_rises", busy_v[0], 1'b1);
    end
    start_v[0] = 1'b0;
    check_eq("hold_one_done", ndone, 1);
    k = 30;
    while (!done_v[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("hold_second_done_at", k, 43);
    check_eq("hold_second_pass", pass_v[0], 1'b1);
    @(negedge clk);

    // Randomized fault tables on the SETTLE=2 instance.
    mode_v[0] = 3;
    for (int it = 0; it < 10; it++) begin
      randomize_faults(0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_sweep(0);
    end

    // SETTLE=1 and SETTLE=255 instances.
    run_sweep(1);
    mode_v[1] = 3;
    for (int it = 0; it < 4; it++) begin
      randomize_faults(1);
      run_sweep(1);
    end
    run_sweep(2);
    mode_v[2] = 3;
    randomize_faults(2);
    run_sweep(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Self-checking stimulus sequencer that sits directly upstream of the two-input mux-built gate bank and also consumes its outputs. On `start`, it drives `a`/`b` through all four input combinations and waits a settle interval per vector. It then samples the seven gate outputs and compares them with the golden truth table. The result is a registered pass/fail verdict plus a per-gate error mask, used for board bring-up and regression.

## Interface

Parameters:
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..255.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high. One clock domain; no other clock.
- `start`  in  1  one-cycle request to run a full sweep; ignored while `busy`.
- `y`  in  7  gate-bank outputs: y[0] AND, y[1] OR, y[2] NOT(a), y[3] NAND, y[4] NOR, y[5] XNOR, y[6] XOR.
- `a`  out  1  stimulus select input to the gate bank (registered).
- `b`  out  1  stimulus data input to the gate bank (registered).
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the verdict is valid.
- `pass`  out  1  sweep verdict; held until the next accepted `start`.
- `err_mask`  out  7  bit i set if gate i mismatched on any vector; held like `pass`.
- `fail_cnt`  out  3  number of vectors (0..4) with at least one mismatch.
- `first_fail`  out  2  vector index {a,b} of the first failing vector; 0 if none.

## Operation

- Golden vector: exp(a,b) = {a^b, ~(a^b), ~(a|b), ~(a&b), ~a, a|b, a&b}, MSB = y[6].
- Vector order: idx 0..3, with {a,b} = idx, i.e. 00, 01, 10, 11.
- States and transitions:
  - IDLE: waits; `start` → DRIVE. On accept, `err_mask`, `fail_cnt`, `first_fail` and `pass` clear and idx = 0.
  - DRIVE: `a`,`b` = idx; the settle counter loads SETTLE-1. DRIVE → WAIT.
  - WAIT: the counter decrements; at 0 → SAMPLE.
  - SAMPLE: `y` is registered into `y_q`.
  - CHECK:
    - mism = y_q ^ exp(idx); `err_mask` |= mism.
    - If mism != 0: `fail_cnt`++, and `first_fail` ← idx if this is the first failing vector.
    - If idx == 3 → DONE; else idx++ → DRIVE.
  - DONE: `done` = 1 for one cycle; `pass` = (`err_mask` == 0) using the final mask, including this sweep's last vector; → IDLE.
- `start` is ignored in every state except IDLE. There is no queueing.
- The `y` input is treated as combinational from `a`/`b`. SETTLE covers the gate-bank propagation delay.
- `fail_cnt` saturates at 4 by construction; idx wraps only through IDLE.

## Timing

- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_mask`=0, `fail_cnt`=0, `first_fail`=0; state IDLE.
- Reset asserted mid-sweep aborts immediately: all outputs return to reset values and no `done` is produced.
- `start` sampled in cycle T → `busy` high at T+1, with the first vector on `a`/`b` at T+1.
- Per vector: 1 (DRIVE) + SETTLE (WAIT) + 1 (SAMPLE) + 1 (CHECK) cycles.
- Sweep latency from `start` to `done` = 4·(SETTLE+3) + 1 cycles. With SETTLE=2 this is 21.
- `busy` deasserts in the cycle after `done`. A `start` in the `done` cycle is ignored; a `start` in the following cycle is accepted.
- `y` is sampled exactly SETTLE+1 cycles after `a`/`b` change.

## Structure

- Shared package `gate_chk_pkg`:
  - state enum (IDLE, DRIVE, WAIT, SAMPLE, CHECK, DONE);
  - gate bit-index localparams (G_AND=0 … G_XOR=6);
  - function `gate_golden(a,b)` returning the 7-bit expected vector.
- One sub-module: `settle_timer`, a loadable down-counter with zero flag, width $clog2(SETTLE+1).
- All state and outputs live in one always block with async reset.

## Test plan

- Correct behavioural gate bank, SETTLE=2, `start` pulse → `done` at cycle 21; `pass`=1, `err_mask`=0, `fail_cnt`=0.
- y[5] and y[6] swapped in the bank model → `pass`=0, `err_mask`=7'b110_0000, `fail_cnt`=4, `first_fail`=0.
- y[0] stuck-at-1 → mismatches on vectors 00, 01, 10. Required: `err_mask`=7'b000_0001, `fail_cnt`=3, `first_fail`=0.
- `rst` pulsed at cycle 9 of a sweep → all outputs 0, no `done`. A subsequent `start` completes normally with `pass`=1.
- `start` held high for 30 cycles → exactly one sweep during `busy`. A second sweep begins at the cycle after `busy` falls; a `start` in the `done` cycle is ignored.
- SETTLE=1 and SETTLE=255 → latency is 17 and 1033 cycles respectively; `a`/`b` follow the sequence 00, 01, 10, 11.
